// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared state type and constants for the LC3 memory responder
package lc3_mem_pkg;

  localparam int WORD_W         = 16;
  localparam int MAX_WAIT       = 15;
  localparam int RAND_EXTRA_MAX = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_DONE_I,
    ST_DONE_D
  } mem_resp_state_e;

endpackage

// File: rtl/lc3_mem_lfsr.sv
// rtl/lc3_mem_lfsr.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11) used for random wait extension
module lc3_mem_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - unified LC3 instruction/data memory responder with programmable wait states
// Optional random wait extension enabled by macro LC3_MEM_RAND_WAIT_EN.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          INSTR_WAIT = 1,
  parameter int          DATA_WAIT  = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       pc,
  input  logic              instrmem_rd,
  output logic [15:0]       Instr_dout,
  output logic              complete_instr,
  input  logic              Data_en,
  input  logic              Data_rd,
  input  logic [15:0]       Data_addr,
  input  logic [15:0]       Data_din,
  output logic [15:0]       Data_dout,
  output logic              complete_data,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data
);

  localparam int W_I = (INSTR_WAIT > MAX_WAIT) ? MAX_WAIT : INSTR_WAIT;
  localparam int W_D = (DATA_WAIT > MAX_WAIT) ? MAX_WAIT : DATA_WAIT;
`ifdef LC3_MEM_RAND_WAIT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + RAND_EXTRA_MAX + 1);
`else
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
`endif

  mem_resp_state_e   r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_extra;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_din;
  logic              r_rd;
  logic [WORD_W-1:0] r_instr_dout;
  logic [WORD_W-1:0] r_data_dout;
  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [WORD_W-1:0] w_mem_wdata;
  logic              w_unused_addr;

  assign w_unused_addr = ^{pc[15:ADDR_W], Data_addr[15:ADDR_W]};

`ifdef LC3_MEM_RAND_WAIT_EN
  logic [15:0] w_lfsr;
  logic [13:0] w_unused_lfsr;

  lc3_mem_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .i_en    (1'b1),
    .o_state (w_lfsr)
  );

  assign w_extra       = CNT_W'(w_lfsr[1:0]);
  assign w_unused_lfsr = w_lfsr[15:2];
`else
  logic w_unused_seed;

  assign w_extra       = '0;
  assign w_unused_seed = ^LFSR_SEED;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Data_en) begin
          w_next_state = ST_BUSY_D;
        end else if (instrmem_rd) begin
          w_next_state = ST_BUSY_I;
        end
      end
      ST_BUSY_I: if (r_cnt == '0) w_next_state = ST_DONE_I;
      ST_BUSY_D: if (r_cnt == '0) w_next_state = ST_DONE_D;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Single write port: backdoor loads only in IDLE, front-door writes only when leaving DONE_D.
  always_comb begin
    complete_instr = (r_state == ST_DONE_I);
    complete_data  = (r_state == ST_DONE_D);
    w_mem_we       = 1'b0;
    w_mem_waddr    = ld_addr;
    w_mem_wdata    = ld_data;
    if (reset && r_state == ST_IDLE && ld_en) begin
      w_mem_we = 1'b1;
    end else if (r_state == ST_DONE_D && !r_rd) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_addr;
      w_mem_wdata = r_din;
    end
  end

  // Read data is captured on the edge entering DONE so it is valid alongside the pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_din        <= '0;
      r_rd         <= 1'b0;
      r_instr_dout <= '0;
      r_data_dout  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Data_en) begin
            r_addr <= Data_addr[ADDR_W-1:0];
            r_din  <= Data_din;
            r_rd   <= Data_rd;
            r_cnt  <= CNT_W'(W_D) + w_extra;
          end else if (instrmem_rd) begin
            r_addr <= pc[ADDR_W-1:0];
            r_cnt  <= CNT_W'(W_I) + w_extra;
          end
        end
        ST_BUSY_I: begin
          if (r_cnt == '0) begin
            r_instr_dout <= r_mem[r_addr];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_BUSY_D: begin
          if (r_cnt == '0) begin
            if (r_rd) r_data_dout <= r_mem[r_addr];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign Instr_dout = r_instr_dout;
  assign Data_dout  = r_data_dout;

endmodule

// File: doc/lc3_mem_responder.md
# lc3_mem_responder

Synthesizable memory-side responder for the LC3 pipeline's instruction and data memory interfaces. It drives `Instr_dout`/`complete_instr` and `Data_dout`/`complete_data` with programmable wait states, replacing bench-driven random memory stimulus with a stateful unified memory. It sits between the `LC3` top level and a single-ported word array. A backdoor load port lets benches preload programs and data.

## Interface
Parameters:
- `ADDR_W`, 10: word-address bits actually decoded; depth = 2^ADDR_W words of 16 bits.
- `INSTR_WAIT`, 1: wait cycles per instruction fetch, 0..15.
- `DATA_WAIT`, 2: wait cycles per data access, 0..15.
- `LFSR_SEED`, 16'hACE1: nonzero seed for the random-wait LFSR; used only when the macro is defined.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `pc`  in  16  instruction fetch address.
- `instrmem_rd`  in  1  fetch request level.
- `Instr_dout`  out  16  fetched instruction word.
- `complete_instr`  out  1  one-cycle fetch completion pulse.
- `Data_en`  in  1  data access request level, driven by the controller while `mem_state` is not idle.
- `Data_rd`  in  1  1 = read, 0 = write; qualified by `Data_en`.
- `Data_addr`  in  16  data word address.
- `Data_din`  in  16  write data.
- `Data_dout`  out  16  read data.
- `complete_data`  out  1  one-cycle data completion pulse.
- `ld_en`  in  1  backdoor write strobe; honoured only in IDLE.
- `ld_addr`  in  ADDR_W  backdoor address.
- `ld_data`  in  16  backdoor data.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- **IDLE request handling.**
  - If `Data_en`=1, latch `Data_addr`, `Data_din`, `Data_rd`, load the wait counter with DATA_WAIT (+extra), and go to BUSY_D.
  - Otherwise, if `instrmem_rd`=1, latch `pc`, load the counter with INSTR_WAIT (+extra), and go to BUSY_I.
  - Data has priority. A fetch that loses arbitration is not latched; it is re-sampled in IDLE after the data access.
- **BUSY_x.** When the counter is 0, go to DONE_x; otherwise decrement the counter.
- **DONE_I.**
  - Register `Instr_dout` = mem[addr[ADDR_W-1:0]].
  - Hold `complete_instr`=1 for this cycle only, then return to IDLE.
- **DONE_D, read.**
  - Register `Data_dout` = mem[addr].
  - Hold `complete_data`=1 for one cycle, then return to IDLE.
- **DONE_D, write.**
  - Write mem[addr] = latched `Data_din` on the edge leaving DONE_D.
  - Leave `Data_dout` unchanged; pulse `complete_data`.
- **Address decode.** Upper address bits are ignored, so addresses alias and wrap modulo 2^ADDR_W.
- **Output hold.** `Instr_dout` and `Data_dout` hold their last value between completions.
- **No re-sampling in DONE.** Requests are never sampled in DONE_x, so a request level still high during completion is not double-served.
- **Backdoor load.** `ld_en` writes in IDLE only. A same-cycle front-door request is still accepted; the backdoor write takes effect first. `ld_en` is ignored outside IDLE.

## Timing
- **Reset (`reset`=0, async):** state IDLE, counter 0, `Instr_dout`=0, `Data_dout`=0, `complete_instr`=0, `complete_data`=0, LFSR=LFSR_SEED. Memory contents are not reset.
- **Reset mid-access:** the access is aborted, no completion is issued, and a pending write is not performed.
- **Latency:** with the request sampled at edge E0, the completion pulse is high from edge E0+W+1 to E0+W+2, where W is the loaded wait value. Output data is valid in the same cycle as the pulse.
- **Throughput:** minimum access period is W+3 cycles (accept, W+1 busy cycles, done).
- **Simultaneous `Data_en` and `instrmem_rd` in IDLE:** data is served first; the fetch completes at the earliest W_I+1 cycles after the cycle following DONE_D.
- **Request dropped while BUSY:** the access still completes and pulses. The requester must hold its request until completion.

## Configuration
- Macro `LC3_MEM_RAND_WAIT_EN`.
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle. At acceptance, extra = lfsr[1:0] (0..3) is added to the base wait; the counter widens to 5 bits.
  - Undefined: waits are exactly INSTR_WAIT/DATA_WAIT, and no LFSR logic exists.

## Structure
- Package `lc3_mem_pkg`: state enum `mem_resp_state_e`, `WORD_W`=16, `MAX_WAIT`=15, `RAND_EXTRA_MAX`=3.
- Sub-module `lc3_mem_lfsr` (seed parameter, enable, 16-bit state out). It is instantiated only under `LC3_MEM_RAND_WAIT_EN`.
- Memory is an inferred array inside `lc3_mem_responder`.

## Test plan
- Reset asserted mid-BUSY_D of a write to 0x010 with 0xBEEF: no `complete_data`; mem[0x010] keeps its old value; all outputs are 0.
- Backdoor-load mem[0x005]=0x1234, INSTR_WAIT=1, `pc`=0x0005 with `instrmem_rd` held high: `complete_instr` is high exactly 2 cycles after the sampling edge, with `Instr_dout`=0x1234, one cycle wide, and no second pulse.
- Write 0xA5A5 to `Data_addr`=0x0403 with ADDR_W=10, then read `Data_addr`=0x0003: `Data_dout`=0xA5A5 (aliasing). Each `complete_data` follows its sampling edge by DATA_WAIT+1 cycles.
- `Data_en` (read 0x020=0x7777) and `instrmem_rd` (pc 0x021=0x1111) raised in the same cycle, waits 1/2: `complete_data` with 0x7777 comes first; `complete_instr` with 0x1111 comes no earlier than 3 cycles later.
- INSTR_WAIT=0, continuous fetch: pulses recur every 3 cycles.
- With `LC3_MEM_RAND_WAIT_EN`, 1000 fetches: every latency lies within 1+INSTR_WAIT..4+INSTR_WAIT, and all four extra values occur.
